// File: rtl/dac.sv
// dac: write-only SPI transmitter for an MCP4911-style 10-bit DAC.
//
// While start_transmit is high, frames are sent back to back. Each frame
// carries the dac_data value latched when the frame starts.
//
// Each frame is a 16-bit word {4'b0011, dac_data, 2'b00}. It is sent
// MSB first in SPI mode 0, and each sclk half-period lasts HALF_PERIOD
// clocks. Between frames, chip select stays high for CS_GAP clocks.
//
// Parameters:
//   HALF_PERIOD  clk cycles per dac_sclk half-period (>= 1)
//   CS_GAP       clk cycles dac_cs stays high between frames (>= 1)
//
// Ports:
//   clk             system clock
//   rst             synchronous reset, active-low
//   dac_data        10-bit sample, latched at frame start
//   start_transmit  level request; frames repeat while high
//   dac_mosi        serial data to the DAC (registered)
//   dac_cs          chip select, active-low (registered)
//   dac_sclk        serial clock, idles low (registered)
module dac #(
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] dac_data,
  input  logic       start_transmit,
  output logic       dac_mosi,
  output logic       dac_cs,
  output logic       dac_sclk
);

  localparam int CNT_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  // GAP is entered one edge after cs rises, and IDLE samples the request
  // one edge after GAP exits. GAP itself therefore lasts CS_GAP-1 cycles.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [3:0]       CMD_BITS = 4'b0011;  // write, unbuffered, 1x, active

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [14:0]      shreg, shreg_n;   // bits still to be sent after dac_mosi
  logic             cs_n, sclk_n, mosi_n;
  logic [15:0]      frame_word_w;

  function automatic logic [15:0] frame_word(input logic [9:0] sample);
    return {CMD_BITS, sample, 2'b00};
  endfunction

  assign frame_word_w = frame_word(dac_data);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    cs_n      = dac_cs;
    sclk_n    = dac_sclk;
    mosi_n    = dac_mosi;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        cs_n   = 1'b1;
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        if (start_transmit) begin
          shreg_n   = frame_word_w[14:0];
          mosi_n    = frame_word_w[15];
          bit_idx_n = 4'd15;
          cs_n      = 1'b0;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt == HP_LAST) begin
          cnt_n = '0;
          if (!dac_sclk) begin
            sclk_n = 1'b1;
          end else begin
            // Falling edge: present the next bit in the same cycle.
            sclk_n = 1'b0;
            if (bit_idx == 4'd0) begin
              state_n = HOLD;
            end else begin
              bit_idx_n = bit_idx - 4'd1;
              mosi_n    = shreg[14];
              shreg_n   = {shreg[13:0], 1'b0};
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      HOLD: begin
        if (cnt == HP_LAST) begin
          cnt_n   = '0;
          cs_n    = 1'b1;
          mosi_n  = 1'b0;
          state_n = (CS_GAP > 1) ? GAP : IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      dac_cs   <= 1'b1;
      dac_sclk <= 1'b0;
      dac_mosi <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      dac_cs   <= cs_n;
      dac_sclk <= sclk_n;
      dac_mosi <= mosi_n;
    end
  end

  // The shift data needs no reset; it is always reloaded at frame start.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_dac.sv
// tb_dac: bench for dac with two instances.
// Instance 0 uses the default parameters (H=2, CS_GAP=4).
// Instance 1 uses H=1, CS_GAP=1.
// A bus monitor rebuilds each frame from the pins. The bench then checks
// the rebuilt frames against the word expected from the sample present at
// the frame's start edge.
module tb_dac;

  localparam int MAXF = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] d0, d1;
  logic       st0, st1;
  logic       cs_o   [2];
  logic       sclk_o [2];
  logic       mosi_o [2];

  always #5 clk = ~clk;

  dac #(.HALF_PERIOD(2), .CS_GAP(4)) u_dac0 (
    .clk(clk), .rst(rst), .dac_data(d0), .start_transmit(st0),
    .dac_mosi(mosi_o[0]), .dac_cs(cs_o[0]), .dac_sclk(sclk_o[0])
  );

  dac #(.HALF_PERIOD(1), .CS_GAP(1)) u_dac1 (
    .clk(clk), .rst(rst), .dac_data(d1), .start_transmit(st1),
    .dac_mosi(mosi_o[1]), .dac_cs(cs_o[1]), .dac_sclk(sclk_o[1])
  );

  // Reference data: the sample each DUT sees at the most recent edge.
  int         cyc = 0;
  logic [9:0] ldata [2];
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ldata[0] <= d0;
    ldata[1] <= d1;
  end

  // Bus monitor. It samples outputs on the falling clock edge.
  logic        pcs   [2] = '{1'b1, 1'b1};
  logic        psclk [2] = '{1'b0, 1'b0};
  logic        pmosi [2] = '{1'b0, 1'b0};
  int          t_fall [2] = '{0, 0};
  int          nbits  [2] = '{0, 0};
  logic [15:0] wacc   [2] = '{16'h0, 16'h0};
  logic [15:0] wexp   [2] = '{16'h0, 16'h0};
  int          n_fall [2] = '{0, 0};
  int          fr_n   [2] = '{0, 0};
  int          bad_edge  [2] = '{0, 0};
  int          glitch    [2] = '{0, 0};
  int          idle_mosi [2] = '{0, 0};
  logic [15:0] fr_word  [2][MAXF];
  logic [15:0] fr_exp   [2][MAXF];
  int          fr_edges [2][MAXF];
  int          fr_low   [2][MAXF];
  int          fr_start [2][MAXF];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pcs[i] === 1'b1 && cs_o[i] === 1'b0) begin
        t_fall[i] = cyc;
        wexp[i]   = {4'b0011, ldata[i], 2'b00};
        nbits[i]  = 0;
        wacc[i]   = 16'h0;
        n_fall[i]++;
      end
      if (cs_o[i] === 1'b0 && sclk_o[i] === 1'b1 && psclk[i] === 1'b0) begin
        wacc[i] = {wacc[i][14:0], mosi_o[i]};
        nbits[i]++;
      end
      if (cs_o[i] === 1'b1 && pcs[i] === 1'b1 && sclk_o[i] !== psclk[i]) bad_edge[i]++;
      if (sclk_o[i] === 1'b1 && psclk[i] === 1'b1 && mosi_o[i] !== pmosi[i]) glitch[i]++;
      if (cs_o[i] === 1'b1 && mosi_o[i] !== 1'b0) idle_mosi[i]++;
      if (pcs[i] === 1'b0 && cs_o[i] === 1'b1) begin
        if (fr_n[i] < MAXF) begin
          fr_word[i][fr_n[i]]  = wacc[i];
          fr_exp[i][fr_n[i]]   = wexp[i];
          fr_edges[i][fr_n[i]] = nbits[i];
          fr_low[i][fr_n[i]]   = cyc - t_fall[i];
          fr_start[i][fr_n[i]] = t_fall[i];
        end
        fr_n[i]++;
      end
      pcs[i]   = cs_o[i];
      psclk[i] = sclk_o[i];
      pmosi[i] = mosi_o[i];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int i, input int n, input string tag);
    for (int k = 0; k < 400 && fr_n[i] < n; k++) step();
    chk(tag, fr_n[i], n);
  endtask

  task automatic wait_fall(input int i, input int n, input string tag);
    for (int k = 0; k < 200 && n_fall[i] < n; k++) step();
    chk(tag, n_fall[i], n);
  endtask

  int          t0, base;
  logic [9:0]  rv [4];
  logic [15:0] ew;

  initial begin
    rst = 1'b0; st0 = 1'b0; st1 = 1'b0; d0 = 10'h0; d1 = 10'h0;

    // Reset and quiet idle.
    repeat (3) step();
    chk("rst_cs0",   cs_o[0],   1);
    chk("rst_sclk0", sclk_o[0], 0);
    chk("rst_mosi0", mosi_o[0], 0);
    chk("rst_cs1",   cs_o[1],   1);
    chk("rst_sclk1", sclk_o[1], 0);
    chk("rst_mosi1", mosi_o[1], 0);
    rst = 1'b1;
    repeat (200) step();
    chk("idle_no_frames0", n_fall[0], 0);
    chk("idle_no_frames1", n_fall[1], 0);
    chk("idle_cs0", cs_o[0], 1);

    // Single frame from a one-cycle pulse.
    d0 = 10'h2AA; st0 = 1'b1; t0 = cyc + 1;
    step();
    st0 = 1'b0;
    wait_frames(0, 1, "single_wait");
    chk("single_word",  fr_word[0][0],  16'h3AA8);
    chk("single_edges", fr_edges[0][0], 16);
    chk("single_low",   fr_low[0][0],   66);
    chk("single_t0",    fr_start[0][0], t0);
    repeat (10) step();

    // Data changed mid-frame is ignored.
    d0 = 10'h3FF; st0 = 1'b1; t0 = cyc + 1;
    step();
    st0 = 1'b0;
    while (cyc < t0 + 10) step();
    d0 = 10'h000;
    wait_frames(0, 2, "stable_wait");
    chk("stable_word",  fr_word[0][1],  16'h3FFC);
    chk("stable_edges", fr_edges[0][1], 16);
    repeat (10) step();

    // Continuous streaming, new random sample each frame, drop mid-frame.
    for (int k = 0; k < 4; k++) rv[k] = 10'($urandom);
    base = fr_n[0];
    d0 = rv[0]; st0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_fall(0, base + k + 1, "stream_fall");
      if (k < 3) d0 = rv[k + 1];
    end
    repeat (20) step();
    st0 = 1'b0;
    d0 = 10'($urandom);
    repeat (300) step();
    chk("stream_count", fr_n[0], base + 4);
    for (int k = 0; k < 4; k++) begin
      ew = {4'b0011, rv[k], 2'b00};
      chk("stream_word",  fr_word[0][base + k],  ew);
      chk("stream_model", fr_exp[0][base + k],   ew);
      chk("stream_edges", fr_edges[0][base + k], 16);
      if (k > 0)
        chk("stream_period", fr_start[0][base + k] - fr_start[0][base + k - 1], 70);
    end

    // Reset mid-frame, then restart with the request still high.
    base = fr_n[0];
    d0 = 10'h155; st0 = 1'b1; t0 = cyc + 1;
    while (cyc < t0 + 19) step();
    rst = 1'b0;
    step();
    chk("midrst_cs",   cs_o[0],   1);
    chk("midrst_sclk", sclk_o[0], 0);
    chk("midrst_mosi", mosi_o[0], 0);
    rst = 1'b1;
    step();
    st0 = 1'b0;
    wait_frames(0, base + 2, "midrst_wait");
    chk("midrst_part_low",   fr_low[0][base],       20);
    chk("midrst_part_edges", fr_edges[0][base],     5);
    chk("midrst_new_t0",     fr_start[0][base + 1], t0 + 21);
    chk("midrst_new_word",   fr_word[0][base + 1],  16'h3554);
    chk("midrst_new_edges",  fr_edges[0][base + 1], 16);

    // Fastest parameters: H=1, CS_GAP=1.
    for (int k = 0; k < 3; k++) rv[k] = 10'($urandom);
    base = fr_n[1];
    d1 = rv[0]; st1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_fall(1, base + k + 1, "sweep_fall");
      if (k < 2) d1 = rv[k + 1];
    end
    repeat (5) step();
    st1 = 1'b0;
    repeat (100) step();
    chk("sweep_count", fr_n[1], base + 3);
    for (int k = 0; k < 3; k++) begin
      ew = {4'b0011, rv[k], 2'b00};
      chk("sweep_word",  fr_word[1][base + k],  ew);
      chk("sweep_edges", fr_edges[1][base + k], 16);
      chk("sweep_low",   fr_low[1][base + k],   33);
      if (k > 0)
        chk("sweep_period", fr_start[1][base + k] - fr_start[1][base + k - 1], 34);
    end

    // Bus rules over the whole run.
    for (int i = 0; i < 2; i++) begin
      chk("sclk_while_cs_high", bad_edge[i],  0);
      chk("mosi_change_sclk_hi", glitch[i],   0);
      chk("mosi_when_cs_high",  idle_mosi[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dac.md
# dac

Write-only SPI transmitter that streams 10-bit samples to an external 10-bit voltage-output DAC (MCP4911-style, 16-bit command word). It sits between the sound generator, which supplies `dac_data` and a `start_transmit` "play" level, and the DAC pins. While `start_transmit` is high it sends back-to-back frames, each carrying the sample latched at frame start.

## Interface
Parameters:
- `HALF_PERIOD`, default 2: number of `clk` cycles per `dac_sclk` half-period. Legal values are ≥1.
- `CS_GAP`, default 4: number of `clk` cycles `dac_cs` stays high between frames. Legal values are ≥1.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset; synchronous, active-low.
- `dac_data`  in  10  sample to transmit; sampled only at frame start.
- `start_transmit`  in  1  level request; while high, frames repeat continuously.
- `dac_mosi`  out  1  serial data, MSB first.
- `dac_cs`  out  1  chip select, active-low.
- `dac_sclk`  out  1  serial clock, SPI mode 0: idles low, DAC samples on the rising edge.

All outputs are registered.

## Operation
- **Frame word (16 bits):** {1'b0 DAC write, 1'b0 unbuffered, 1'b1 gain 1x, 1'b1 active, dac_data[9:0], 2'b00}. This equals {4'b0011, dac_data, 2'b00}.
- **States:**
  - IDLE: `dac_cs`=1, `dac_sclk`=0, `dac_mosi`=0.
    - If `start_transmit`=1 at a clock edge: latch the frame word, drive `dac_cs`=0, drive `dac_mosi`=bit15, go to SHIFT.
  - SHIFT, 16 bits:
    - Each bit spends HALF_PERIOD cycles with sclk low, then HALF_PERIOD cycles with sclk high.
    - On the sclk falling edge, `dac_mosi` advances to the next bit in the same cycle.
    - After bit0's high phase, sclk returns to 0 and the state goes to HOLD.
  - HOLD: `dac_cs` stays low for HALF_PERIOD cycles, `dac_mosi` holds bit0. Then `dac_cs`=1, `dac_mosi`=0, go to GAP.
  - GAP: `dac_cs` stays high for CS_GAP cycles, then go to IDLE.
- **Input timing:**
  - `dac_data` changes after the latch edge do not affect the current frame.
  - `start_transmit` is checked only in IDLE. Dropping it mid-frame does not abort; the frame completes, then the block idles.
- **Reset:** `rst`=0 at any edge, including mid-frame, forces IDLE with `dac_cs`=1, `dac_sclk`=0, `dac_mosi`=0 on that edge. A partial frame is abandoned; the DAC discards it because CS rises early.
- Exactly 16 rising sclk edges occur per frame with `dac_cs` low. No sclk edges occur while `dac_cs` is high.

## Timing
Let t0 be the edge at which IDLE samples `start_transmit`=1, and H = HALF_PERIOD.
- `dac_cs` falls and bit15 appears at t0.
- For bit k (15…0):
  - sclk rises at t0+(15−k)·2H+H.
  - sclk falls at t0+(16−k)·2H.
  - The next bit appears on that falling edge.
- Last sclk fall is at t0+32H. `dac_cs` rises at t0+33H.
- The earliest next t0 is t0+33H+CS_GAP. With defaults this is 70 cycles per frame.
- Setup and hold: data is stable for H cycles before and H cycles after each rising sclk edge.
- Latency from a `start_transmit` rise (registered at edge e while IDLE) to `dac_cs` low is edge e itself.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → `dac_cs`=1, `dac_sclk`=0, `dac_mosi`=0. With `start_transmit`=0 afterwards, no activity for 200 cycles.
- **Single frame:** `dac_data`=10'h2AA; pulse `start_transmit` high for 1 cycle in IDLE → bits captured on sclk rising edges are 16'h3AA8, exactly 16 edges, `dac_cs` low for 33H=66 cycles.
- **Data stability:** `dac_data`=10'h3FF at t0, changed to 10'h000 at t0+10 → frame is 16'h3FFC.
- **Continuous streaming:** hold `start_transmit`=1 and change `dac_data` each frame → frames start every 70 cycles and each carries the value present at its t0. Drop `start_transmit` mid-frame → that frame completes and no further frame starts.
- **Reset mid-frame:** assert `rst`=0 at t0+20 → outputs return to 1/0/0 on that edge. After release with `start_transmit`=1, a full new frame starts at the next IDLE edge.
- **Parameter sweep:** HALF_PERIOD=1, CS_GAP=1 → 34-cycle frame period and correct 16'h3xxx words.
